// File: rtl/prt_read_scheduler_if.sv
// prt_read_scheduler_if -- PRT access handshakes and egress byte stream of the read scheduler.
//   master : scheduler side (drives EN_*, slot selects, tx_data/tx_valid/tx_last)
//   slave  : PRT / downstream side (drives RDY_*, read_prt_entry, tx_ready)
//   Signals: EN/RDY_start_reading_prt_entry + slot, EN/RDY_read_prt_entry + read_prt_entry
//            (MSB = end marker), EN/RDY_invalidate_prt_entry + slot, tx_data/valid/last/ready.
interface prt_read_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SLOTS  = 10
);
   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

   logic                  EN_start_reading_prt_entry;
   logic [SLOT_W-1:0]     start_reading_prt_entry_slot;
   logic                  RDY_start_reading_prt_entry;

   logic                  EN_read_prt_entry;
   logic                  RDY_read_prt_entry;
   logic [DATA_WIDTH:0]   read_prt_entry;

   logic                  EN_invalidate_prt_entry;
   logic [SLOT_W-1:0]     invalidate_prt_entry_slot;
   logic                  RDY_invalidate_prt_entry;

   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_last;
   logic                  tx_ready;

   modport master (
      output EN_start_reading_prt_entry, start_reading_prt_entry_slot,
      input  RDY_start_reading_prt_entry,
      output EN_read_prt_entry,
      input  RDY_read_prt_entry, read_prt_entry,
      output EN_invalidate_prt_entry, invalidate_prt_entry_slot,
      input  RDY_invalidate_prt_entry,
      output tx_data, tx_valid, tx_last,
      input  tx_ready
   );

   modport slave (
      input  EN_start_reading_prt_entry, start_reading_prt_entry_slot,
      output RDY_start_reading_prt_entry,
      input  EN_read_prt_entry,
      output RDY_read_prt_entry, read_prt_entry,
      input  EN_invalidate_prt_entry, invalidate_prt_entry_slot,
      output RDY_invalidate_prt_entry,
      input  tx_data, tx_valid, tx_last,
      output tx_ready
   );
endinterface

// File: rtl/prt_read_scheduler.sv
// prt_read_scheduler -- drains committed PRT slots in commit order: start read, stream bytes into
// an egress FIFO (last flag on the final byte), then invalidate the slot.
//   CLK, RST           : clock, synchronous active-high reset
//   commit_valid/slot  : one-cycle notice that a slot finished writing (queued FIFO order)
//   bus (master)       : PRT start/read/invalidate handshakes and tx egress stream
//   queue_count, busy  : commit queue occupancy, FSM not idle
//   overflow           : sticky, a commit was dropped because the queue was full
//   zero_len           : one-cycle pulse, frame ended with no data bytes
//   timeout_err        : one-cycle pulse, watchdog expired in START or INVAL
// Optional: define PRT_SCHED_TIMEOUT_EN to build the handshake watchdog; otherwise waits are
// unbounded and timeout_err is tied low.
module prt_read_scheduler #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_SLOTS      = 10,
   parameter int unsigned OUT_DEPTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   localparam int unsigned SLOT_W        = $clog2(NUM_SLOTS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                commit_valid,
   input  logic [SLOT_W-1:0]   commit_slot,
   prt_read_scheduler_if.master bus,
   output logic [SLOT_W:0]     queue_count,
   output logic                busy,
   output logic                overflow,
   output logic                zero_len,
   output logic                timeout_err
);
   localparam int unsigned PTR_W = $clog2(OUT_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StRead, StInval} state_t;

   state_t                state;
   logic [SLOT_W-1:0]     cur_slot;
   logic [DATA_WIDTH-1:0] staged;
   logic                  staged_vld;
   logic                  read_first;

   // ---------------- commit queue ----------------
   logic [SLOT_W-1:0] q_mem [NUM_SLOTS];
   logic [SLOT_W-1:0] q_rd, q_wr;
   logic              q_full, q_pop, q_push;

   assign q_full = (queue_count == (SLOT_W+1)'(NUM_SLOTS));
   assign q_pop  = (state == StIdle) && (queue_count != '0);
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign q_push = commit_valid && (!q_full || q_pop);

   function automatic logic [SLOT_W-1:0] q_next(input logic [SLOT_W-1:0] p);
      return (p == SLOT_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_rd        <= '0;
         q_wr        <= '0;
         queue_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (q_push) begin
            q_mem[q_wr] <= commit_slot;
            q_wr        <= q_next(q_wr);
         end
         if (q_pop) q_rd <= q_next(q_rd);
         case ({q_push, q_pop})
            2'b10:   queue_count <= queue_count + 1'b1;
            2'b01:   queue_count <= queue_count - 1'b1;
            default: ;
         endcase
         if (commit_valid && !q_push) overflow <= 1'b1;
      end
   end

   // ---------------- egress FIFO ----------------
   logic [DATA_WIDTH:0] f_mem [OUT_DEPTH];
   logic [PTR_W-1:0]    f_rd, f_wr;
   logic [PTR_W:0]      f_cnt;
   logic                f_push, f_pop, room;
   logic [DATA_WIDTH:0] f_wdata;

   // Two free entries: one for the staged byte, one spare for the frame-end push.
   assign room         = (f_cnt <= (PTR_W+1)'(OUT_DEPTH - 2));
   assign bus.tx_valid = (f_cnt != '0);
   assign bus.tx_data  = bus.tx_valid ? f_mem[f_rd][DATA_WIDTH-1:0] : '0;
   assign bus.tx_last  = bus.tx_valid && f_mem[f_rd][DATA_WIDTH];
   assign f_pop        = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         f_rd  <= '0;
         f_wr  <= '0;
         f_cnt <= '0;
      end else begin
         if (f_push) begin
            f_mem[f_wr] <= f_wdata;
            f_wr        <= f_wr + 1'b1;
         end
         if (f_pop) f_rd <= f_rd + 1'b1;
         case ({f_push, f_pop})
            2'b10:   f_cnt <= f_cnt + 1'b1;
            2'b01:   f_cnt <= f_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- read datapath ----------------
   logic marker, capture, frame_end;

   assign marker                = bus.read_prt_entry[DATA_WIDTH];
   assign bus.EN_read_prt_entry = (state == StRead) && bus.RDY_read_prt_entry && room;
   assign capture               = bus.EN_read_prt_entry && !marker;
   // RDY low ends the frame, except on the first READ cycle where the PRT may still be waking up.
   assign frame_end             = (state == StRead) && room &&
                                  (bus.RDY_read_prt_entry ? marker : !read_first);
   // Staged byte goes out when displaced by a new capture, or as the last byte at frame end.
   assign f_push                = staged_vld && (capture || frame_end);
   assign f_wdata               = {frame_end, staged};

   // ---------------- watchdog ----------------
   logic wd_hit;
`ifdef PRT_SCHED_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic            waiting;
   logic [WD_W-1:0] wd_cnt;

   assign waiting = ((state == StStart) && !bus.RDY_start_reading_prt_entry) ||
                    ((state == StInval) && !bus.RDY_invalidate_prt_entry);
   assign wd_hit  = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Any cycle that is not a stalled wait (including every state change) clears the count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt      <= (waiting && !wd_hit) ? wd_cnt + 1'b1 : '0;
         timeout_err <= wd_hit;
      end
   end
`else
   assign wd_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= StIdle;
         cur_slot   <= '0;
         staged     <= '0;
         staged_vld <= 1'b0;
         read_first <= 1'b0;
         zero_len   <= 1'b0;
      end else begin
         zero_len <= 1'b0;
         case (state)
            StIdle: begin
               if (q_pop) begin
                  cur_slot <= q_mem[q_rd];
                  state    <= StStart;
               end
            end
            StStart: begin
               if (bus.RDY_start_reading_prt_entry) begin
                  state      <= StRead;
                  read_first <= 1'b1;
                  staged_vld <= 1'b0;
               end else if (wd_hit) begin
                  state <= StInval;
               end
            end
            StRead: begin
               read_first <= 1'b0;
               if (capture) begin
                  staged     <= bus.read_prt_entry[DATA_WIDTH-1:0];
                  staged_vld <= 1'b1;
               end
               if (frame_end) begin
                  staged_vld <= 1'b0;
                  zero_len   <= !staged_vld;
                  state      <= StInval;
               end
            end
            StInval: begin
               if (bus.RDY_invalidate_prt_entry || wd_hit) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy                             = (state != StIdle);
   assign bus.EN_start_reading_prt_entry   = (state == StStart);
   assign bus.start_reading_prt_entry_slot = (state == StStart) ? cur_slot : '0;
   assign bus.EN_invalidate_prt_entry      = (state == StInval);
   assign bus.invalidate_prt_entry_slot    = (state == StInval) ? cur_slot : '0;
endmodule

// File: tb/tb_prt_read_scheduler.sv
// Bench for prt_read_scheduler: behavioural PRT model plus directed frames with hand-computed
// expected tx bytes, slot orders and status flags.
module tb_prt_read_scheduler;
   localparam int unsigned DW = 8;
   localparam int unsigned NS = 10;
   localparam int unsigned SW = $clog2(NS);
   localparam int unsigned TO = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic          commit_valid;
   logic [SW-1:0] commit_slot;
   logic [SW:0]   queue_count;
   logic          busy, overflow, zero_len, timeout_err;

   prt_read_scheduler_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus ();

   prt_read_scheduler #(
      .DATA_WIDTH    (DW),
      .NUM_SLOTS     (NS),
      .OUT_DEPTH     (4),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .commit_valid(commit_valid),
      .commit_slot (commit_slot),
      .bus         (bus),
      .queue_count (queue_count),
      .busy        (busy),
      .overflow    (overflow),
      .zero_len    (zero_len),
      .timeout_err (timeout_err)
   );

   always #5 CLK = ~CLK;

   // ---------------- PRT model and monitors ----------------
   logic [7:0]    data_tab [16][8];
   int            len_tab  [16];
   logic [SW-1:0] m_slot = '0;
   int            m_idx  = 0;

   assign bus.read_prt_entry = (m_idx < len_tab[m_slot]) ?
                               {1'b0, data_tab[m_slot][m_idx[2:0]]} : {1'b1, 8'h00};

   logic [SW-1:0] start_log[$];
   logic [SW-1:0] inval_log[$];
   logic [DW:0]   tx_log[$];
   int            zl_cnt = 0, to_cnt = 0, txv_cnt = 0, onehot_err = 0;

   always @(posedge CLK) begin
      if (bus.EN_start_reading_prt_entry && bus.RDY_start_reading_prt_entry) begin
         start_log.push_back(bus.start_reading_prt_entry_slot);
         m_slot <= bus.start_reading_prt_entry_slot;
         m_idx  <= 0;
      end
      if (bus.EN_read_prt_entry && bus.RDY_read_prt_entry && !bus.read_prt_entry[DW])
         m_idx <= m_idx + 1;
      if (bus.EN_invalidate_prt_entry && bus.RDY_invalidate_prt_entry)
         inval_log.push_back(bus.invalidate_prt_entry_slot);
      if (bus.tx_valid && bus.tx_ready) tx_log.push_back({bus.tx_last, bus.tx_data});
      if (zero_len) zl_cnt++;
      if (timeout_err) to_cnt++;
      if (bus.tx_valid) txv_cnt++;
      if (int'(bus.EN_start_reading_prt_entry) + int'(bus.EN_read_prt_entry) +
          int'(bus.EN_invalidate_prt_entry) > 1) onehot_err++;
   end

   // ---------------- helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic commit(input int s);
      commit_valid = 1'b1;
      commit_slot  = SW'(s);
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while ((busy || bus.tx_valid || queue_count != '0) && k < 2000) begin
         tick();
         k++;
      end
      check_eq({tag, "_drain"}, 32'(k < 2000), 1);
   endtask

   task automatic clear_logs();
      start_log.delete();
      inval_log.delete();
      tx_log.delete();
      zl_cnt  = 0;
      to_cnt  = 0;
      txv_cnt = 0;
   endtask

   function automatic logic [31:0] tx_at(input int k);
      return (k < tx_log.size()) ? 32'(tx_log[k]) : 32'hdead;
   endfunction

   function automatic logic [31:0] st_at(input int k);
      return (k < start_log.size()) ? 32'(start_log[k]) : 32'hdead;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_en"}, {bus.EN_start_reading_prt_entry, bus.EN_read_prt_entry,
                              bus.EN_invalidate_prt_entry}, 0);
      check_eq({tag, "_slots"}, {bus.start_reading_prt_entry_slot,
                                 bus.invalidate_prt_entry_slot}, 0);
      check_eq({tag, "_tx"}, {bus.tx_valid, bus.tx_last, bus.tx_data}, 0);
      check_eq({tag, "_qcount"}, queue_count, 0);
      check_eq({tag, "_status"}, {busy, overflow, zero_len, timeout_err}, 0);
   endtask

   // ---------------- stimulus ----------------
   int          ovf_ids [10] = '{0, 2, 3, 5, 6, 7, 8, 9, 0, 2};
   int          n4;
   int          n;
   logic [DW:0] exp9;

   initial begin
      for (int s = 0; s < 16; s++) begin
         len_tab[s] = 1;
         for (int k = 0; k < 8; k++) data_tab[s][k] = {s[3:0], 4'h5};
      end
      data_tab[3][0] = 8'hA1; data_tab[3][1] = 8'hB2; data_tab[3][2] = 8'hC3; len_tab[3] = 3;
      for (int k = 0; k < 8; k++) data_tab[6][k] = 8'h60 + 8'(k);
      len_tab[6] = 8;

      RST          = 1'b1;
      commit_valid = 1'b0;
      commit_slot  = '0;
      bus.RDY_start_reading_prt_entry = 1'b1;
      bus.RDY_read_prt_entry          = 1'b1;
      bus.RDY_invalidate_prt_entry    = 1'b1;
      bus.tx_ready                    = 1'b1;
      tick(3);
      RST = 1'b0;
      check_idle_outputs("reset");

      // Single frame A1,B2,C3 from slot 3.
      clear_logs();
      commit(3);
      wait_drain("frame3");
      check_eq("frame3_len", tx_log.size(), 3);
      check_eq("frame3_b0", tx_at(0), {1'b0, 8'hA1});
      check_eq("frame3_b1", tx_at(1), {1'b0, 8'hB2});
      check_eq("frame3_b2", tx_at(2), {1'b1, 8'hC3});
      check_eq("frame3_inval_n", inval_log.size(), 1);
      check_eq("frame3_inval_slot", (inval_log.size() > 0) ? 32'(inval_log[0]) : 32'hdead, 3);

      // Commit order 5,2,7 queued behind a held slot 9.
      clear_logs();
      bus.RDY_start_reading_prt_entry = 1'b0;
      commit(9);
      commit(5);
      commit(2);
      commit(7);
      check_eq("order_qcount3", queue_count, 3);
      bus.RDY_start_reading_prt_entry = 1'b1;
      wait_drain("order");
      check_eq("order_qcount0", queue_count, 0);
      check_eq("order_n", start_log.size(), 4);
      check_eq("order_s0", st_at(0), 9);
      check_eq("order_s1", st_at(1), 5);
      check_eq("order_s2", st_at(2), 2);
      check_eq("order_s3", st_at(3), 7);
      check_eq("order_tx1", tx_at(1), {1'b1, 8'h55});

      // Overflow: NUM_SLOTS+1 commits while the current frame is held in START.
      clear_logs();
      bus.RDY_start_reading_prt_entry = 1'b0;
      commit(1);
      for (int i = 0; i < 10; i++) commit(ovf_ids[i]);
      check_eq("ovf_full_qcount", queue_count, 10);
      check_eq("ovf_not_yet", overflow, 0);
      commit(4);
      check_eq("ovf_set", overflow, 1);
      check_eq("ovf_qcount_held", queue_count, 10);
      bus.RDY_start_reading_prt_entry = 1'b1;
      wait_drain("ovf");
      check_eq("ovf_n", start_log.size(), 11);
      check_eq("ovf_first", st_at(0), 1);
      for (int i = 0; i < 10; i++) check_eq($sformatf("ovf_s%0d", i + 1), st_at(i + 1), ovf_ids[i]);
      n4 = 0;
      foreach (start_log[i]) if (start_log[i] == SW'(4)) n4++;
      check_eq("ovf_drop_absent", n4, 0);
      check_eq("ovf_sticky", overflow, 1);

      // Egress stall: 8-byte frame, tx_ready low for 20 cycles.
      clear_logs();
      bus.tx_ready = 1'b0;
      commit(6);
      tick(20);
      check_eq("stall_en_read", bus.EN_read_prt_entry, 0);
      check_eq("stall_busy", busy, 1);
      check_eq("stall_head", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h60});
      check_eq("stall_consumed", m_idx, 4);
      bus.tx_ready = 1'b1;
      wait_drain("stall");
      check_eq("stall_n", tx_log.size(), 8);
      for (int k = 0; k < 8; k++) begin
         exp9 = {(k == 7), 8'h60 + 8'(k)};
         check_eq($sformatf("stall_b%0d", k), tx_at(k), exp9);
      end

      // Zero-length frame.
      clear_logs();
      len_tab[4] = 0;
      commit(4);
      wait_drain("zl");
      check_eq("zl_pulse", zl_cnt, 1);
      check_eq("zl_no_tx", txv_cnt, 0);
      check_eq("zl_inval", (inval_log.size() == 1) ? 32'(inval_log[0]) : 32'hdead, 4);
      len_tab[4] = 1;

      // START never acknowledged.
      clear_logs();
      bus.RDY_start_reading_prt_entry = 1'b0;
      commit(2);
      tick();
`ifdef PRT_SCHED_TIMEOUT_EN
      check_eq("to_busy", busy, 1);
      n = 0;
      while (!timeout_err && n < int'(TO) + 10) begin
         tick();
         n++;
      end
      check_eq("to_cycle", n, TO);
      wait_drain("to");
      check_eq("to_pulses", to_cnt, 1);
      check_eq("to_inval", (inval_log.size() == 1) ? 32'(inval_log[0]) : 32'hdead, 2);
      check_eq("to_no_start", start_log.size(), 0);
      bus.RDY_start_reading_prt_entry = 1'b1;
`else
      tick(60);
      check_eq("noto_pulses", to_cnt, 0);
      check_eq("noto_waiting", {busy, bus.EN_start_reading_prt_entry}, 2'b11);
      check_eq("noto_slot", bus.start_reading_prt_entry_slot, 2);
      bus.RDY_start_reading_prt_entry = 1'b1;
      wait_drain("noto");
      check_eq("noto_start", st_at(0), 2);
`endif

      // Reset mid-frame discards the partial frame, no invalidate, clears sticky overflow.
      clear_logs();
      bus.tx_ready = 1'b0;
      commit(6);
      tick(10);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check_idle_outputs("midrst");
      tick(5);
      check_eq("midrst_no_inval", inval_log.size(), 0);
      check_eq("midrst_idle", {busy, bus.tx_valid}, 0);
      bus.tx_ready = 1'b1;

      check_eq("en_onehot", onehot_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
